dmem_loader: RTL and testbench
==============================

// Module: dmem_loader
// PURPOSE
//  Program RAM plus boot loader sitting directly on the dCPU memory bus.
//  - After reset it accepts a program as a byte stream and writes it from address 0 upward.
//  - It pads the rest of memory with NOP, holding the CPU in reset the whole time.
//  - It then releases the CPU and serves its active-low R/W accesses as an async-read / sync-write RAM.
// PARAMETERS
//  ADDR_W    8      address width; depth = 2**ADDR_W bytes
//  DATA_W    8      data width
//  RST_HOLD  4      cycles cpu_rst stays high after fill completes (1..15)
//  FILL_VAL  8'h90  pad byte written to unloaded locations (NOP opcode)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       reset, asynchronous, active-high
//  in_data     in   DATA_W  loader stream byte
//  in_valid    in   1       in_data valid
//  in_last     in   1       qualifies the final byte of the program
//  in_ready    out  1       loader accepts a byte this cycle
//  load_req    in   1       request a reload (sampled only in RUN)
//  cpu_rst     out  1       reset to dCPU; high while loading/filling/holding
//  cpu_addr    in   ADDR_W  CPU address register
//  cpu_R       in   1       CPU read strobe, active-low
//  cpu_W       in   1       CPU write strobe, active-low
//  cpu_wdata   in   DATA_W  CPU data bus out
//  cpu_rdata   out  DATA_W  read data to CPU (mem_in)
//  load_done   out  1       high in RUN
//  prog_len    out  ADDR_W+1  bytes accepted in the last load (0..2**ADDR_W)
//  err_rw      out  1       sticky: R and W both low on a clock edge in RUN
// BEHAVIOUR
//  - Reset values (async): state=LOAD, wr_ptr=0, hold_cnt=0, prog_len=0, err_rw=0.
//    Resulting outputs: in_ready=1, cpu_rst=1, load_done=0, cpu_rdata=0.
//  - RAM contents are not reset.
//  - States: LOAD -> FILL -> HOLD -> RUN -> (load_req) LOAD.
//  - LOAD:
//    - in_ready=1.
//    - Handshake fires when in_valid&in_ready.
//      - mem[wr_ptr]<=in_data, wr_ptr++ (ADDR_W+1 bits), prog_len<=wr_ptr+1.
//    - Fire with in_last -> FILL.
//    - Fire that fills the last location (wr_ptr==2**ADDR_W-1) -> HOLD directly.
//      This applies whether or not in_last is set; wr_ptr wraps to 0.
//    - in_valid low: no change; no timeout.
//  - FILL:
//    - in_ready=0.
//    - Each cycle mem[wr_ptr]<=FILL_VAL, wr_ptr++.
//    - After writing the top location -> HOLD.
//    - Fill latency = 2**ADDR_W - prog_len cycles.
//  - HOLD:
//    - hold_cnt counts 0..RST_HOLD-1; on RST_HOLD-1 -> RUN and hold_cnt<=0.
//  - RUN:
//    - cpu_rst=0, load_done=1.
//    - cpu_rdata = (!cpu_R) ? mem[cpu_addr] : 0. Combinational, same cycle.
//    - !cpu_W at posedge: mem[cpu_addr]<=cpu_wdata.
//      A write-then-read of the same address returns the new value the cycle after.
//    - !cpu_R&&!cpu_W at posedge: write still performed; err_rw<=1.
//      err_rw is cleared only by rst or by entering LOAD.
//    - load_req=1 -> LOAD next cycle.
//      On that transition: wr_ptr<=0, err_rw<=0, cpu_rst rises the same edge.
//      A CPU write on that edge is still committed.
//  - Outside RUN:
//    - cpu_rdata=0, CPU strobes ignored, err_rw not updated, load_req ignored.
//  - cpu_rst = (state!=RUN). Registered state, so glitch-free.
//  - Reset mid-load or mid-fill:
//    - Returns to LOAD at address 0; partially written contents are left as-is.
//  - prog_len behaviour:
//    - Holds its value through FILL/HOLD/RUN.
//    - Reloads from 0 as bytes arrive in the next LOAD.
//    - Full-memory load reports 2**ADDR_W.
// TESTING
//  1. Stream C0,63,CA,C3,05(last), one per cycle
//     -> mem[0..4] match the stream, mem[5..255]=90, prog_len=5.
//     -> cpu_rst falls exactly 251+RST_HOLD cycles after the last handshake.
//  2. Gapped stream: in_valid toggling 1/0 for 3 bytes
//     -> only valid cycles are written, wr_ptr advances only on fire, prog_len=3.
//  3. 256 bytes streamed, in_last never asserted
//     -> no FILL cycles, HOLD entered after byte 256, prog_len=256, wr_ptr wraps to 0.
//  4. RUN: W=0 addr=FE data=63, then R=0 addr=FE
//     -> cpu_rdata=63 the next cycle; cpu_rdata=0 whenever R=1.
//  5. RUN: R=0 and W=0 together -> err_rw=1 and stays 1.
//     Then load_req -> cpu_rst=1, in_ready=1, err_rw=0 next cycle.
//  6. rst pulse mid-FILL -> immediate LOAD, in_ready=1, cpu_rst=1.
//     A new 2-byte load then completes normally with prog_len=2.

Source files
------------

// File: rtl/dmem_loader.sv
// dmem_loader: program RAM with byte-stream boot loader, NOP padding and CPU reset sequencing
module dmem_loader #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                RST_HOLD = 4,
    parameter logic [DATA_W-1:0] FILL_VAL = 'h90
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              load_req,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_R,
    input  logic              cpu_W,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len,
    output logic              err_rw
);

    typedef enum logic [1:0] {LOAD, FILL, HOLD, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, ptr_inc;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              err_rw_q, err_rw_d;
    logic              mem_we, at_top;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign ptr_inc   = wr_ptr_q + (ADDR_W+1)'(1);
    assign at_top    = &wr_ptr_q[ADDR_W-1:0];
    assign in_ready  = state_q == LOAD;
    assign load_done = state_q == RUN;
    assign cpu_rst   = state_q != RUN;
    assign prog_len  = prog_len_q;
    assign err_rw    = err_rw_q;
    assign cpu_rdata = (load_done && !cpu_R) ? mem[cpu_addr] : '0;

    // next state and the single RAM write port shared by loader, filler and CPU
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        prog_len_d = prog_len_q;
        err_rw_d   = err_rw_q;
        mem_we     = 1'b0;
        mem_addr   = wr_ptr_q[ADDR_W-1:0];
        mem_wdata  = in_data;
        unique case (state_q)
            LOAD: begin
                mem_we = in_valid;
                if (in_valid) begin
                    wr_ptr_d   = ptr_inc;
                    prog_len_d = ptr_inc;
                    if (at_top) begin
                        state_d  = HOLD;
                        wr_ptr_d = '0;
                    end else if (in_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_wdata = FILL_VAL;
                wr_ptr_d  = ptr_inc;
                if (at_top) begin
                    state_d  = HOLD;
                    wr_ptr_d = '0;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 4'd1;
                if (hold_cnt_q == 4'(RST_HOLD - 1)) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end
            end
            RUN: begin
                mem_we    = !cpu_W;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (!cpu_R && !cpu_W) err_rw_d = 1'b1;
                if (load_req) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    err_rw_d   = 1'b0;
                    prog_len_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // control registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            wr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            prog_len_q <= '0;
            err_rw_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            prog_len_q <= prog_len_d;
            err_rw_q   <= err_rw_d;
        end
    end

    // RAM array, not reset; writes suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: randomized self-checking bench for dmem_loader against a flat memory-image model
module tb_dmem_loader;

    localparam int DEPTH    = 256;
    localparam int RST_HOLD = 4;

    logic       clk, rst;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready, load_req, cpu_rst;
    logic [7:0] cpu_addr;
    logic       cpu_R, cpu_W;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       load_done;
    logic [8:0] prog_len;
    logic       err_rw;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ref_mem [DEPTH];

    dmem_loader #(.ADDR_W(8), .DATA_W(8), .RST_HOLD(RST_HOLD), .FILL_VAL(8'h90)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .load_req(load_req), .cpu_rst(cpu_rst), .cpu_addr(cpu_addr),
        .cpu_R(cpu_R), .cpu_W(cpu_W), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .load_done(load_done), .prog_len(prog_len), .err_rw(err_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: back-to-back, 1: random gaps, 2: valid toggles 1/0
    task automatic stream_load(input int len, input bit use_last, input int mode);
        logic [7:0] bytes [DEPTH];
        int i = 0;
        int cyc = 0;
        for (int k = 0; k < len; k++) bytes[k] = 8'($urandom);
        while (i < len && cyc < 5000) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
            in_data  = in_valid ? bytes[i] : 8'($urandom);
            in_last  = in_valid ? (use_last && i == len - 1) : 1'($urandom_range(0, 1));
            check("in_ready_load", in_ready, 1);
            @(posedge clk); #1;
            cyc++;
            if (in_valid) begin
                i++;
                check("prog_len_stream", prog_len, i);
            end
        end
        check("stream_done", i, len);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = (k < len) ? bytes[k] : 8'h90;
    endtask

    task automatic wait_run(input int exp_cycles, input int exp_len);
        int n = 0;
        check("in_ready_after_load", in_ready, 0);
        while (cpu_rst && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_release_latency", n, exp_cycles);
        check("load_done_run", load_done, 1);
        check("prog_len_run", prog_len, exp_len);
    endtask

    task automatic readback();
        cpu_W = 1'b1;
        cpu_R = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            cpu_addr = 8'(a);
            @(negedge clk);
            check("readback", cpu_rdata, ref_mem[a]);
        end
        cpu_R = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cpu_op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        cpu_R = r; cpu_W = w; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        check("cpu_rdata", cpu_rdata, !r ? ref_mem[a] : 8'h00);
        @(posedge clk); #1;
        if (!w) ref_mem[a] = d;
        cpu_R = 1'b1; cpu_W = 1'b1;
    endtask

    task automatic reload();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        check("reload_cpu_rst", cpu_rst, 1);
        check("reload_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; load_req = 1'b0;
        cpu_R = 1'b0; cpu_W = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_load_done", load_done, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_err_rw", err_rw, 0);
        cpu_R = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        begin
            logic [7:0] prog [5] = '{8'hC0, 8'h63, 8'hCA, 8'hC3, 8'h05};
            for (int k = 0; k < 5; k++) begin
                in_valid = 1'b1; in_data = prog[k]; in_last = (k == 4);
                @(posedge clk); #1;
            end
            in_valid = 1'b0; in_last = 1'b0;
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = (k < 5) ? prog[k] : 8'h90;
            check("prog_len_fixed", prog_len, 5);
            wait_run(251 + RST_HOLD, 5);
            readback();
        end

        check("read_idle_zero", cpu_rdata, 0);
        cpu_op(1'b1, 1'b0, 8'hFE, 8'h63);
        cpu_op(1'b0, 1'b1, 8'hFE, 8'h00);
        check("read_fe_value", ref_mem[8'hFE], 8'h63);
        for (int k = 0; k < 200; k++) begin
            int op = $urandom_range(0, 2);
            cpu_op(op != 0, op != 1, 8'($urandom), 8'($urandom));
        end
        check("err_rw_clean", err_rw, 0);

        cpu_op(1'b0, 1'b0, 8'h10, 8'h5A);
        check("err_rw_set", err_rw, 1);
        repeat (3) cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        check("err_rw_sticky", err_rw, 1);
        cpu_op(1'b0, 1'b1, 8'h10, 8'h00);
        load_req = 1'b1;
        cpu_op(1'b1, 1'b0, 8'h20, 8'hAA);
        load_req = 1'b0;
        check("req_cpu_rst", cpu_rst, 1);
        check("req_in_ready", in_ready, 1);
        check("req_err_rw", err_rw, 0);
        check("req_load_done", load_done, 0);
        cpu_R = 1'b0; #1;
        check("req_rdata_zero", cpu_rdata, 0);
        cpu_R = 1'b1;
        @(posedge clk); #1;

        stream_load(3, 1'b1, 2);
        wait_run(253 + RST_HOLD, 3);
        readback();

        reload();
        stream_load(DEPTH, 1'b0, 1);
        wait_run(RST_HOLD, DEPTH);
        readback();

        for (int r = 0; r < 2; r++) begin
            int len = (r == 0) ? DEPTH : $urandom_range(1, DEPTH - 1);
            reload();
            stream_load(len, 1'b1, 1);
            wait_run(DEPTH - len + RST_HOLD, len);
            readback();
        end

        reload();
        stream_load(10, 1'b1, 0);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midfill_in_ready", in_ready, 1);
        check("midfill_cpu_rst", cpu_rst, 1);
        check("midfill_prog_len", prog_len, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        stream_load(2, 1'b1, 0);
        wait_run(254 + RST_HOLD, 2);
        readback();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
